// File: rtl/mem_access_if.sv
// Memory-side bus of the access unit: one outstanding request at a time.
// Handshake: mem_req stays high with mem_addr/mem_we/mem_wdata stable until the cycle mem_ack is sampled high; mem_ack outside a request is ignored.
interface mem_access_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// CPU memory access unit: PC/IR/MDR registers plus a single-transaction
// IDLE/REQ/DONE sequencer with a wait-cycle timeout and sticky error flag.
module mem_access_unit (
  input  logic              CLK,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              LDW_EN,
  input  logic              PC_EN,
  input  logic              BR_EN,
  input  logic              IR_EN,
  input  logic              MDR_EN,
  input  logic [15:0]       addr_reg,
  input  logic [15:0]       data_reg,
  input  logic [15:0]       br_target,
  mem_access_if.master      mem,
  output logic [15:0]       PC,
  output logic [15:0]       IR,
  output logic [15:0]       MDR,
  output logic              busy,
  output logic              err,
  output logic [1:0]        fsm_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] WAIT_LIMIT = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        load_mdr_q, load_mdr_d;
  logic [15:0] rbuf_q, rbuf_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pc_q, pc_d;
  logic        err_q, err_d;
  logic        start;
  logic        conflict;
  logic        ack_rd;

  assign start    = MemRead ^ MemWrite;
  assign conflict = MemRead & MemWrite;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      wait_q     <= 4'd0;
      addr_q     <= 16'h0000;
      wdata_q    <= 16'h0000;
      we_q       <= 1'b0;
      load_mdr_q <= 1'b0;
      rbuf_q     <= 16'h0000;
      mdr_q      <= 16'h0000;
      ir_q       <= 16'h0000;
      pc_q       <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      load_mdr_q <= load_mdr_d;
      rbuf_q     <= rbuf_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    load_mdr_d = load_mdr_q;
    rbuf_d     = rbuf_q;
    mdr_d      = mdr_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    err_d      = err_q;
    ack_rd     = 1'b0;

    // PC runs independently of the sequencer; a branch overrides increment.
    if (BR_EN) begin
      pc_d = br_target;
    end else if (PC_EN) begin
      pc_d = pc_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (conflict) begin
          err_d = 1'b1;
        end else if (start) begin
          addr_d     = LDW_EN ? addr_reg : pc_q;
          wdata_d    = data_reg;
          we_d       = MemWrite;
          load_mdr_d = MDR_EN;
          wait_d     = 4'd0;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (MemRead || MemWrite) begin
          err_d = 1'b1;
        end
        if (mem.mem_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            ack_rd = 1'b1;
            rbuf_d = mem.mem_rdata;
            if (load_mdr_q) begin
              mdr_d = mem.mem_rdata;
            end
          end
        end else begin
          // Counter reaching the limit means 15 REQ cycles went by unanswered.
          wait_d = wait_q + 4'd1;
          if (wait_d == WAIT_LIMIT) begin
            wait_d  = 4'd0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DONE: begin
        if (MemRead || MemWrite) begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (IR_EN) begin
      ir_d = ack_rd ? mem.mem_rdata : rbuf_q;
    end
  end

  assign mem.mem_req   = (state_q == S_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign PC          = pc_q;
  assign IR          = ir_q;
  assign MDR         = mdr_q;
  assign busy        = (state_q != S_IDLE);
  assign err         = err_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: per-cycle vector table plus hand-written
// timeout sequence, with an address scoreboard watching request starts.
module tb_mem_access_unit;

  typedef struct {
    logic        rst_n, rd, wr, ldw, pc_en, br_en, ir_en, mdr_en, ack;
    logic [15:0] addr, data, brt, rdata;
    logic        e_req, e_we, e_busy, e_err;
    logic [15:0] e_addr, e_wdata, e_pc, e_ir, e_mdr;
  } vec_t;

  localparam int NV = 30;

  logic        CLK;
  logic        reset;
  logic        MemRead, MemWrite, LDW_EN, PC_EN, BR_EN, IR_EN, MDR_EN;
  logic [15:0] addr_reg, data_reg, br_target;
  logic [15:0] PC, IR, MDR;
  logic        busy, err;
  logic [1:0]  fsm_state;

  mem_access_if bus ();

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        prev_req = 1'b0;
  vec_t        tbl[NV];

  mem_access_unit dut (
    .CLK         (CLK),
    .reset       (reset),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .LDW_EN      (LDW_EN),
    .PC_EN       (PC_EN),
    .BR_EN       (BR_EN),
    .IR_EN       (IR_EN),
    .MDR_EN      (MDR_EN),
    .addr_reg    (addr_reg),
    .data_reg    (data_reg),
    .br_target   (br_target),
    .mem         (bus),
    .PC          (PC),
    .IR          (IR),
    .MDR         (MDR),
    .busy        (busy),
    .err         (err),
    .fsm_state_o (fsm_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Checking helpers
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [8:0] ctl, input logic [15:0] addr, input logic [15:0] data,
                              input logic [15:0] brt, input logic [15:0] rdata, input logic [3:0] flags,
                              input logic [15:0] ea, input logic [15:0] ew, input logic [15:0] ep,
                              input logic [15:0] ei, input logic [15:0] em);
    vec_t v;
    {v.rst_n, v.rd, v.wr, v.ldw, v.pc_en, v.br_en, v.ir_en, v.mdr_en, v.ack} = ctl;
    v.addr = addr; v.data = data; v.brt = brt; v.rdata = rdata;
    {v.e_req, v.e_we, v.e_busy, v.e_err} = flags;
    v.e_addr = ea; v.e_wdata = ew; v.e_pc = ep; v.e_ir = ei; v.e_mdr = em;
    return v;
  endfunction

  // Driver tasks
  task automatic drive(input vec_t v);
    reset         = v.rst_n;
    MemRead       = v.rd;
    MemWrite      = v.wr;
    LDW_EN        = v.ldw;
    PC_EN         = v.pc_en;
    BR_EN         = v.br_en;
    IR_EN         = v.ir_en;
    MDR_EN        = v.mdr_en;
    bus.mem_ack   = v.ack;
    addr_reg      = v.addr;
    data_reg      = v.data;
    br_target     = v.brt;
    bus.mem_rdata = v.rdata;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t idle_v();
    return mk(9'b1_0000_0000, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0000,
              16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
  endfunction

  // Scoreboard: every new request must present the next expected address
  always @(negedge CLK) begin
    if (bus.mem_req === 1'b1 && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected_req: got addr %h expected no request", bus.mem_addr);
      end else begin
        check16("mon_req_addr", bus.mem_addr, exp_q.pop_front());
      end
    end
    prev_req = (bus.mem_req === 1'b1);
  end

  initial begin
    vec_t v;
    logic prev_e_req;
    int   req_cycles;

    //               rst rd wr ldw pce bre ire mdre ack   addr      data      brt       rdata      req we busy err  addr      wdata     pc        ir        mdr
    tbl[0]  = mk(9'b0_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(9'b1_0_0_0_0_1_0_0_0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 16'h0000);
    tbl[2]  = mk(9'b1_1_0_0_1_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h0010, 16'h0000, 16'h0011, 16'h0000, 16'h0000);
    tbl[3]  = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h0010, 16'h0000, 16'h0011, 16'h0000, 16'h0000);
    tbl[4]  = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h0010, 16'h0000, 16'h0011, 16'h0000, 16'h0000);
    tbl[5]  = mk(9'b1_0_0_0_0_0_0_0_1, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 4'b0010, 16'h0010, 16'h0000, 16'h0011, 16'h0000, 16'h0000);
    tbl[6]  = mk(9'b1_0_0_0_0_0_1_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0010, 16'h0000, 16'h0011, 16'h1234, 16'h0000);
    tbl[7]  = mk(9'b1_1_0_1_0_0_0_1_0, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h00A0, 16'h0000, 16'h0011, 16'h1234, 16'h0000);
    tbl[8]  = mk(9'b1_0_0_0_0_0_0_0_1, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 4'b0010, 16'h00A0, 16'h0000, 16'h0011, 16'h1234, 16'hBEEF);
    tbl[9]  = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h00A0, 16'h0000, 16'h0011, 16'h1234, 16'hBEEF);
    tbl[10] = mk(9'b1_0_1_1_0_0_0_0_0, 16'h0040, 16'h5A5A, 16'h0000, 16'h0000, 4'b1110, 16'h0040, 16'h5A5A, 16'h0011, 16'h1234, 16'hBEEF);
    tbl[11] = mk(9'b1_0_0_0_0_0_0_0_0, 16'h9999, 16'h1111, 16'h0000, 16'h0000, 4'b1110, 16'h0040, 16'h5A5A, 16'h0011, 16'h1234, 16'hBEEF);
    tbl[12] = mk(9'b1_0_0_0_0_0_0_0_1, 16'h0000, 16'h0000, 16'h0000, 16'hDEAD, 4'b0110, 16'h0040, 16'h5A5A, 16'h0011, 16'h1234, 16'hBEEF);
    tbl[13] = mk(9'b1_0_0_0_0_0_1_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 16'h0040, 16'h5A5A, 16'h0011, 16'hBEEF, 16'hBEEF);
    tbl[14] = mk(9'b1_0_0_0_0_1_0_0_0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 4'b0100, 16'h0040, 16'h5A5A, 16'hFFFF, 16'hBEEF, 16'hBEEF);
    tbl[15] = mk(9'b1_0_0_0_1_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0100, 16'h0040, 16'h5A5A, 16'h0000, 16'hBEEF, 16'hBEEF);
    tbl[16] = mk(9'b1_0_0_0_1_1_0_0_0, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 4'b0100, 16'h0040, 16'h5A5A, 16'h0200, 16'hBEEF, 16'hBEEF);
    tbl[17] = mk(9'b1_1_1_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0101, 16'h0040, 16'h5A5A, 16'h0200, 16'hBEEF, 16'hBEEF);
    tbl[18] = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0101, 16'h0040, 16'h5A5A, 16'h0200, 16'hBEEF, 16'hBEEF);
    tbl[19] = mk(9'b1_1_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1011, 16'h0200, 16'h0000, 16'h0200, 16'hBEEF, 16'hBEEF);
    tbl[20] = mk(9'b0_0_0_0_0_0_0_1_1, 16'h0000, 16'h0000, 16'h0000, 16'h7777, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[21] = mk(9'b1_0_0_0_0_0_1_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[22] = mk(9'b1_0_0_0_0_0_0_0_1, 16'h0000, 16'h0000, 16'h0000, 16'h3333, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[23] = mk(9'b1_1_0_1_0_0_0_1_0, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[24] = mk(9'b1_0_0_0_0_0_1_0_1, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 4'b0010, 16'h0300, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);
    tbl[25] = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 16'h0300, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);
    tbl[26] = mk(9'b1_1_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1010, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);
    tbl[27] = mk(9'b1_0_1_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b1011, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);
    tbl[28] = mk(9'b1_0_0_0_0_0_0_0_1, 16'h0000, 16'h0000, 16'h0000, 16'h4444, 4'b0011, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);
    tbl[29] = mk(9'b1_0_0_0_0_0_0_0_0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 16'h0000, 16'h0000, 16'h0000, 16'hCAFE, 16'hCAFE);

    drive(tbl[0]);
    prev_e_req = 1'b0;
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i]);
      if (tbl[i].e_req && !prev_e_req) exp_q.push_back(tbl[i].e_addr);
      prev_e_req = tbl[i].e_req;
      tick();
      check16($sformatf("v%0d_mem_req", i),   {15'd0, bus.mem_req}, {15'd0, tbl[i].e_req});
      check16($sformatf("v%0d_mem_we", i),    {15'd0, bus.mem_we},  {15'd0, tbl[i].e_we});
      check16($sformatf("v%0d_busy", i),      {15'd0, busy},        {15'd0, tbl[i].e_busy});
      check16($sformatf("v%0d_err", i),       {15'd0, err},         {15'd0, tbl[i].e_err});
      check16($sformatf("v%0d_mem_addr", i),  bus.mem_addr,  tbl[i].e_addr);
      check16($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
      check16($sformatf("v%0d_pc", i),        PC,  tbl[i].e_pc);
      check16($sformatf("v%0d_ir", i),        IR,  tbl[i].e_ir);
      check16($sformatf("v%0d_mdr", i),       MDR, tbl[i].e_mdr);
    end

    // Timeout: reset, preload MDR/rbuf with 0x1357, then a read nobody answers
    v = idle_v(); v.rst_n = 1'b0; drive(v); tick();
    v = idle_v(); v.rd = 1'b1; v.ldw = 1'b1; v.mdr_en = 1'b1; v.addr = 16'h0100;
    exp_q.push_back(16'h0100);
    drive(v); tick();
    v = idle_v(); v.ack = 1'b1; v.rdata = 16'h1357; drive(v); tick();
    v = idle_v(); drive(v); tick();
    check16("pre_timeout_mdr", MDR, 16'h1357);
    check16("pre_timeout_err", {15'd0, err}, 16'h0000);

    v = idle_v(); v.rd = 1'b1; v.ldw = 1'b1; v.mdr_en = 1'b1; v.addr = 16'h0ABC;
    exp_q.push_back(16'h0ABC);
    drive(v); tick();
    v = idle_v(); v.rdata = 16'hFFFF; drive(v);
    req_cycles = (bus.mem_req === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40 && bus.mem_req === 1'b1; c++) begin
      tick();
      if (bus.mem_req === 1'b1) req_cycles++;
    end
    check16("timeout_req_cycles", 16'(req_cycles), 16'd15);
    check16("timeout_err", {15'd0, err}, 16'h0001);
    check16("timeout_busy", {15'd0, busy}, 16'h0000);
    check16("timeout_state", {14'd0, fsm_state}, 16'h0000);
    check16("timeout_mdr", MDR, 16'h1357);

    // Late ack in IDLE is ignored; IR_EN then exposes the untouched rbuf
    v = idle_v(); v.ack = 1'b1; v.rdata = 16'h2468; v.ir_en = 1'b1; drive(v); tick();
    check16("late_ack_ir", IR, 16'h1357);
    check16("late_ack_busy", {15'd0, busy}, 16'h0000);
    v = idle_v(); drive(v); tick();
    check16("exp_q_empty", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports, clock and reset first (name  direction  width  meaning):
- CLK  in  1  CPU clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- MemRead  in  1  control-FSM request for a memory read
- MemWrite  in  1  control-FSM request for a memory write
- LDW_EN  in  1  address select: 1 = addr_reg, 0 = PC
- PC_EN  in  1  PC increment enable
- BR_EN  in  1  PC load from br_target
- IR_EN  in  1  IR load from read buffer
- MDR_EN  in  1  route the current read's data into MDR
- addr_reg  in  16  load/store address from the register file
- data_reg  in  16  store data from the register file
- br_target  in  16  branch destination
- mem_rdata  in  16  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion strobe
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  1 = write transaction
- mem_addr  out  16  transaction address
- mem_wdata  out  16  transaction write data
- PC  out  16  program counter
- IR  out  16  instruction register
- MDR  out  16  memory data register
- busy  out  1  transaction in flight
- err  out  1  sticky protocol/timeout error

Function
REQ-002 SHALL implement a three-state FSM: IDLE, REQ, DONE.
REQ-003 In IDLE, MemRead xor MemWrite high SHALL start a transaction: latch mem_addr = (LDW_EN ? addr_reg : PC), mem_wdata = data_reg, mem_we = MemWrite, capture flag load_mdr = MDR_EN; go to REQ next cycle.
REQ-004 In IDLE, MemRead and MemWrite both high SHALL start no transaction and SHALL set err.
REQ-005 In REQ, mem_req SHALL be 1; mem_addr, mem_wdata and mem_we SHALL be stable until exit.
REQ-006 In REQ, mem_ack=1 SHALL move to DONE; a read SHALL write mem_rdata into the 16-bit read buffer rbuf, and into MDR when load_mdr=1, on that edge.
REQ-007 In REQ, a 4-bit wait counter SHALL clear on entry and increment each cycle without ack; if it reaches 15 with no ack, SHALL abort to IDLE, set err, and leave rbuf/MDR unchanged.
REQ-008 DONE SHALL last exactly one cycle, then return to IDLE.
REQ-009 busy SHALL be 1 in REQ and DONE, 0 in IDLE; minimum latency request-to-idle is 3 cycles (ack in the first REQ cycle).
REQ-010 MemRead/MemWrite arriving while not in IDLE SHALL be ignored and SHALL set err.
REQ-011 mem_ack while not in REQ SHALL be ignored.
REQ-012 PC update SHALL be independent of the FSM: BR_EN -> PC <= br_target; else PC_EN -> PC <= PC + 1 (16-bit, 0xFFFF wraps to 0x0000); BR_EN wins if both high.
REQ-013 A transaction starting in the same cycle as PC_EN SHALL use the pre-increment PC.
REQ-014 IR_EN SHALL load IR <= rbuf on its edge; if IR_EN coincides with the ack edge, IR SHALL take mem_rdata (bypass).
REQ-015 err SHALL stay set until reset.

Reset
REQ-016 reset=0 at a rising CLK edge SHALL force IDLE, PC=0x0000, IR=0x0000, MDR=0x0000, rbuf=0x0000, wait counter=0, err=0, mem_req=0, mem_we=0, mem_addr=0x0000, mem_wdata=0x0000, busy=0.
REQ-017 Reset in REQ SHALL drop mem_req on the next edge; any ack arriving on that same edge SHALL be discarded.

Verification
REQ-018 Fetch: PC=0x0010, MemRead=1, PC_EN=1, LDW_EN=0; ack 2 cycles later with 0x1234; IR_EN -> mem_addr=0x0010, PC=0x0011, IR=0x1234, busy high for 4 cycles.
REQ-019 Load: MemRead=1, LDW_EN=1, MDR_EN=1, addr_reg=0x00A0; ack with 0xBEEF -> mem_addr=0x00A0, MDR=0xBEEF, IR unchanged.
REQ-020 Store: MemWrite=1, LDW_EN=1, addr_reg=0x0040, data_reg=0x5A5A -> mem_we=1, mem_wdata=0x5A5A held until ack, MDR unchanged.
REQ-021 Timeout: MemRead with ack never asserted -> mem_req drops after 15 REQ cycles, err=1, MDR/rbuf unchanged.
REQ-022 Branch/wrap: PC=0xFFFF, PC_EN=1 -> 0x0000; then BR_EN=1 with PC_EN=1, br_target=0x0200 -> PC=0x0200.
REQ-023 Conflicts: MemRead and MemWrite both high -> no mem_req, err=1; reset=0 mid-REQ -> mem_req=0, PC=0x0000, err=0 next cycle.
